// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - shared widths and request/response types for the SRAM port-0 controller
package sram_ctrl_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 9;
    localparam int NUM_WMASKS = DATA_WIDTH / 8;

    typedef logic [DATA_WIDTH-1:0] sram_rdata_t;

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rsp_fifo.sv
// rtl/sram_rsp_fifo.sv - show-ahead response FIFO that exports its occupancy
module sram_rsp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    localparam int PTR_W     = $clog2(DEPTH),
    localparam int OCC_W     = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_tvalid,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [OCC_W-1:0]      occupancy
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  push, pop;

    // The writer never pushes into a full FIFO: credits are reserved upstream.
    assign push      = s_tvalid;
    assign pop       = m_tvalid && m_tready;
    assign m_tvalid  = (occ_q != '0);
    assign m_tdata   = mem_q[rd_ptr_q];
    assign occupancy = occ_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            if (push) begin
                mem_q[wr_ptr_q] <= s_tdata;
            end
        end
    end

endmodule

// File: rtl/sram_port0_ctrl.sv
// rtl/sram_port0_ctrl.sv - RW port-0 controller for the 1rw1r 32x512 macro; SRAM_CTRL_RDATA_CHECK_EN adds rsp_x_err
module sram_port0_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RSP_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef SRAM_CTRL_RDATA_CHECK_EN
    ,
    output logic                  rsp_x_err
`endif
);

    localparam int OCC_W = $clog2(RSP_DEPTH) + 1;
    localparam int CNT_W = $clog2(RSP_DEPTH) + 2;

    sram_req_t             req;
    logic                  accept;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  rd_p1_q, rd_p1_d;
    logic                  rd_p2_q, rd_p2_d;
    logic [OCC_W-1:0]      occ;
    logic [CNT_W-1:0]      credits_used;
    sram_rdata_t           fifo_rdata;

    assign req = '{we: req_we, wmask: req_wmask, addr: req_addr, wdata: req_wdata};

    // Credits cover every read still in the pipe, so a full FIFO can never be overrun.
    assign credits_used = CNT_W'(rd_p1_q) + CNT_W'(rd_p2_q) + CNT_W'(occ);
    assign req_ready    = (credits_used < CNT_W'(RSP_DEPTH));
    assign accept       = req_valid && req_ready;

    always_comb begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = '0;
        addr_d  = addr_q;
        din_d   = din_q;
        rd_p1_d = accept && !req.we;
        rd_p2_d = rd_p1_q;
        if (accept) begin
            csb_d   = 1'b0;
            web_d   = !req.we;
            wmask_d = req.we ? req.wmask : '0;
            addr_d  = req.addr;
            din_d   = req.wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            rd_p1_q <= 1'b0;
            rd_p2_q <= 1'b0;
        end else begin
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            rd_p1_q <= rd_p1_d;
            rd_p2_q <= rd_p2_d;
        end
    end

    assign sram_csb0   = csb_q;
    assign sram_web0   = web_q;
    assign sram_wmask0 = wmask_q;
    assign sram_addr0  = addr_q;
    assign sram_din0   = din_q;

    // dout0 is valid one full cycle after the macro latched the read.
    sram_rsp_fifo #(
        .DATA_WIDTH(DATA_WIDTH),
        .DEPTH     (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_tvalid (rd_p2_q),
        .s_tdata  (sram_dout0),
        .m_tvalid (rsp_valid),
        .m_tready (rsp_ready),
        .m_tdata  (fifo_rdata),
        .occupancy(occ)
    );

    assign rsp_rdata = fifo_rdata;

`ifdef SRAM_CTRL_RDATA_CHECK_EN
    logic x_err_q, x_err_d;

    always_comb begin
        x_err_d = rd_p2_q && ((^sram_dout0) !== 1'b0) && ((^sram_dout0) !== 1'b1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_err_q <= 1'b0;
        end else begin
            x_err_q <= x_err_d;
        end
    end

    assign rsp_x_err = x_err_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n && x_err_d) begin
            $error("sram_port0_ctrl: unknown read data from addr pipeline");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// tb/tb_sram_port0_ctrl.sv - directed self-checking bench with a behavioural port-0 macro model
module tb_sram_port0_ctrl;
    import sram_ctrl_pkg::*;

    logic                  clk;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [NUM_WMASKS-1:0] req_wmask;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  sram_csb0;
    logic                  sram_web0;
    logic [NUM_WMASKS-1:0] sram_wmask0;
    logic [ADDR_WIDTH-1:0] sram_addr0;
    logic [DATA_WIDTH-1:0] sram_din0;
    logic [DATA_WIDTH-1:0] sram_dout0 = '0;
`ifdef SRAM_CTRL_RDATA_CHECK_EN
    logic                  rsp_x_err;
`endif

    int errors = 0;
    int checks = 0;
    int rcvd   = 0;
    logic sb_en  = 1'b0;
    logic tog_en = 1'b0;
    logic [31:0] exp_q [$];

    sram_port0_ctrl #(.RSP_DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_wmask  (req_wmask),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .sram_csb0  (sram_csb0),
        .sram_web0  (sram_web0),
        .sram_wmask0(sram_wmask0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_dout0 (sram_dout0)
`ifdef SRAM_CTRL_RDATA_CHECK_EN
        ,
        .rsp_x_err  (rsp_x_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Macro model: command latched at posedge, write/read performed at the following negedge.
    logic [31:0] mem [512];
    logic        m_csb = 1'b1;
    logic        m_web = 1'b1;
    logic [3:0]  m_wmask = '0;
    logic [8:0]  m_addr = '0;
    logic [31:0] m_din = '0;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
    end

    always @(posedge clk) begin
        m_csb   = sram_csb0;
        m_web   = sram_web0;
        m_wmask = sram_wmask0;
        m_addr  = sram_addr0;
        m_din   = sram_din0;
    end

    always @(negedge clk) begin
        if (!m_csb) begin
            if (!m_web) begin
                for (int b = 0; b < 4; b++) begin
                    if (m_wmask[b]) mem[m_addr][b*8 +: 8] = m_din[b*8 +: 8];
                end
            end else begin
                sram_dout0 = mem[m_addr];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        logic        hs;
        logic [31:0] d;
        hs = sb_en && rsp_valid && rsp_ready;
        d  = rsp_rdata;
        @(posedge clk);
        #2;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("sb_extra_rsp", 32'd1, 32'd0);
            end else begin
                check("sb_data", d, exp_q.pop_front());
                rcvd++;
            end
        end
        if (tog_en) rsp_ready = ~rsp_ready;
    endtask

    task automatic issue(input logic we, input logic [8:0] addr, input logic [31:0] data,
                         input logic [3:0] mask);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_wmask = mask;
        cycle();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp);
        for (int i = 0; i < 8 && !rsp_valid; i++) cycle();
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_data"}, rsp_rdata, exp);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_wmask = '0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_ctl", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'h30);
        check("rst_addr", 32'(sram_addr0), 32'h0);
        check("rst_din", sram_din0, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);

        // Idle: csb, web, wmask, req_ready, rsp_valid packed as 1,1,0000,1,0
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle", 32'({sram_csb0, sram_web0, sram_wmask0, req_ready, rsp_valid}), 32'hC2);
        end

        // Full write then read-after-write on consecutive cycles
        issue(1'b1, 9'h005, 32'hDEADBEEF, 4'hF);
        check("wr_ctl", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'h0F);
        check("wr_addr", 32'(sram_addr0), 32'h005);
        check("wr_din", sram_din0, 32'hDEADBEEF);
        issue(1'b0, 9'h005, 32'h0, 4'h0);
        check("rd_ctl", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'h10);
        cycle();
        check("rd_idle_ctl", 32'({sram_csb0, sram_web0, sram_wmask0}), 32'h30);
        check("rd_lat1_valid", 32'(rsp_valid), 32'd0);
        cycle();
        check("rd_lat2_valid", 32'(rsp_valid), 32'd1);
        check("raw_data", rsp_rdata, 32'hDEADBEEF);
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        check("raw_popped", 32'(rsp_valid), 32'd0);

        // Partial write at the top address
        issue(1'b1, 9'h1FF, 32'hAAAAAAAA, 4'hF);
        issue(1'b1, 9'h1FF, 32'h11223344, 4'h5);
        check("pw_wmask", 32'(sram_wmask0), 32'h5);
        issue(1'b0, 9'h1FF, 32'h0, 4'h0);
        wait_rsp("pw", 32'hAA22AA44);

        // Fill the credit window with four reads while the consumer stalls
        for (int i = 0; i < 4; i++) issue(1'b1, 9'(i), 32'h1000 + 32'(i), 4'hF);
        for (int i = 0; i < 4; i++) begin
            check("full_ready_before", 32'(req_ready), 32'd1);
            issue(1'b0, 9'(i), 32'h0, 4'h0);
        end
        check("full_ready_after4", 32'(req_ready), 32'd0);
        req_valid = 1'b1;
        req_we    = 1'b0;
        req_addr  = 9'h003;
        cycle();
        req_valid = 1'b0;
        check("full_no_accept_csb", 32'(sram_csb0), 32'd1);
        cycle();
        check("full_ready_held", 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_valid", 32'(rsp_valid), 32'd1);
            check("drain_data", rsp_rdata, 32'h1000 + 32'(i));
            cycle();
            if (i == 0) check("ready_after_pop", 32'(req_ready), 32'd1);
        end
        check("drain_empty", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b0;

        // Interleaved W,R,W,R with a toggling consumer against a scoreboard
        sb_en  = 1'b1;
        tog_en = 1'b1;
        rcvd   = 0;
        issue(1'b1, 9'h010, 32'hCAFE0010, 4'hF);
        exp_q.push_back(32'hCAFE0010);
        issue(1'b0, 9'h010, 32'h0, 4'h0);
        issue(1'b1, 9'h011, 32'hBEEF0011, 4'hF);
        exp_q.push_back(32'hBEEF0011);
        issue(1'b0, 9'h011, 32'h0, 4'h0);
        for (int i = 0; i < 20 && rcvd < 2; i++) cycle();
        check("sb_count", 32'(rcvd), 32'd2);
        check("sb_left", 32'(exp_q.size()), 32'd0);
        tog_en = 1'b0;
        sb_en  = 1'b0;
        rsp_ready = 1'b0;
        cycle();
        check("sb_no_extra", 32'(rsp_valid), 32'd0);

        // Reset with two reads in flight
        issue(1'b0, 9'h010, 32'h0, 4'h0);
        issue(1'b0, 9'h011, 32'h0, 4'h0);
        check("inflight_csb", 32'(sram_csb0), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_csb", 32'(sram_csb0), 32'd1);
        check("async_rst_valid", 32'(rsp_valid), 32'd0);
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("post_rst_no_rsp", 32'(rsp_valid), 32'd0);
        end
        issue(1'b0, 9'h1FF, 32'h0, 4'h0);
        wait_rsp("post_rst_rd", 32'hAA22AA44);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
